// File: rtl/axi_ar_error_responder_if.sv
// Bundle between the AR decoder, the R channel sink and the read-side
// decode-error responder. The slave modport is the responder's view.
interface axi_ar_error_responder_if #(
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_DATA_WIDTH = 64
);
  logic                      sample_ardata_info_i;
  logic [AXI_ID_WIDTH-1:0]   arid_i;
  logic [7:0]                arlen_i;
  logic [AXI_USER_WIDTH-1:0] aruser_i;
  logic                      error_req_i;
  logic                      outstanding_trans_i;
  logic                      error_gnt_o;
  logic                      rvalid_o;
  logic                      rready_i;
  logic [AXI_ID_WIDTH-1:0]   rid_o;
  logic [AXI_DATA_WIDTH-1:0] rdata_o;
  logic [1:0]                rresp_o;
  logic                      rlast_o;
  logic [AXI_USER_WIDTH-1:0] ruser_o;
  logic                      busy_o;

  modport slave (
    input  sample_ardata_info_i, arid_i, arlen_i, aruser_i, error_req_i,
           outstanding_trans_i, rready_i,
    output error_gnt_o, rvalid_o, rid_o, rdata_o, rresp_o, rlast_o,
           ruser_o, busy_o
  );

  modport master (
    output sample_ardata_info_i, arid_i, arlen_i, aruser_i, error_req_i,
           outstanding_trans_i, rready_i,
    input  error_gnt_o, rvalid_o, rid_o, rdata_o, rresp_o, rlast_o,
           ruser_o, busy_o
  );
endinterface

// File: rtl/axi_ar_error_responder.sv
// Read-side decode-error responder. Captures a rejected AR, waits for older
// reads of the port to drain, then returns ARLEN+1 error beats on R and
// grants the decoder on the last beat.
// Optional feature macro: AXI_ERR_RESP_SLVERR_EN (SLVERR instead of DECERR).
module axi_ar_error_responder #(
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  axi_ar_error_responder_if.slave r_if
);

`ifdef AXI_ERR_RESP_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b11;
`endif

  typedef enum logic [1:0] {IDLE, DRAIN, RESP} state_e;

  state_e                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
  logic [AXI_USER_WIDTH-1:0] ruser_q, ruser_d;
  logic                      in_resp;
  logic                      last_beat;

  // The decoder request is only informational; sequencing uses the strobe.
  logic unused_error_req;
  assign unused_error_req = r_if.error_req_i;

  assign in_resp   = (state_q == RESP);
  assign last_beat = in_resp && (cnt_q == 8'd0);

  // Next-state logic: capture in IDLE only, drain, then count beats down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rid_d   = rid_q;
    ruser_d = ruser_q;
    case (state_q)
      IDLE: begin
        if (r_if.sample_ardata_info_i) begin
          state_d = DRAIN;
          cnt_d   = r_if.arlen_i;
          rid_d   = r_if.arid_i;
          ruser_d = r_if.aruser_i;
        end
      end
      DRAIN: begin
        if (!r_if.outstanding_trans_i) state_d = RESP;
      end
      RESP: begin
        // Counter stops at zero: the last handshake leaves instead of wrapping.
        if (r_if.rready_i) begin
          if (cnt_q == 8'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rid_q   <= '0;
      ruser_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rid_q   <= rid_d;
      ruser_q <= ruser_d;
    end
  end

  // R channel driven straight from state so reset drops rvalid at once.
  assign r_if.rvalid_o    = in_resp;
  assign r_if.rlast_o     = last_beat;
  assign r_if.error_gnt_o = last_beat && r_if.rready_i;
  assign r_if.busy_o      = (state_q != IDLE);
  assign r_if.rid_o       = rid_q;
  assign r_if.ruser_o     = ruser_q;
  assign r_if.rdata_o     = '0;
  assign r_if.rresp_o     = ERR_RESP;

endmodule
